// File: rtl/pwl_sweep_pkg.sv
// Shared field codes, sweep-register bit positions and FSM encoding for the sweep engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwl_sweep_pkg;

    // Register field selector, the low two bits of wr_addr
    localparam logic [1:0] FIELD_PERIOD = 2'd0;
    localparam logic [1:0] FIELD_AMP    = 2'd1;
    localparam logic [1:0] FIELD_SWEEP0 = 2'd2;
    localparam logic [1:0] FIELD_SWEEP1 = 2'd3;

    // Sweep register layout
    localparam int SW_EN         = 15;
    localparam int SW_DIR        = 14;
    localparam int SW_SHIFT      = 8;
    localparam int SW_SHIFT_BITS = 4;
    localparam int SW_RATE       = 0;
    localparam int SW_RATE_BITS  = 8;

    typedef logic [15:0] sweep_t;
    typedef logic [SW_RATE_BITS-1:0] presc_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pwl_sweep_if.sv
// Register-write front end and oscillator-facing outputs of the sweep engine.
// Latency: n/a (wiring only).
// Backpressure: none; writes and ticks are single-cycle strobes always accepted.
interface pwl_sweep_if #(
    parameter int NUM_CH      = 4,
    parameter int PERIOD_BITS = 13,
    parameter int AMP_BITS    = 6
);
    localparam int CH_BITS = $clog2(NUM_CH);

    logic                          wr_en;
    logic [CH_BITS+1:0]            wr_addr;
    logic [15:0]                   wr_data;
    logic                          tick;
    logic                          clr_overrun;
    logic [NUM_CH*PERIOD_BITS-1:0] periods;
    logic [NUM_CH*AMP_BITS-1:0]    amps;
    logic [2*NUM_CH-1:0]           sat;
    logic                          busy;
    logic                          overrun;

    // Front end drives writes and ticks, reads back the channel state
    modport master (
        output wr_en, wr_addr, wr_data, tick, clr_overrun,
        input  periods, amps, sat, busy, overrun
    );

    // Sweep engine side
    modport slave (
        input  wr_en, wr_addr, wr_data, tick, clr_overrun,
        output periods, amps, sat, busy, overrun
    );
endinterface

// File: rtl/pwl_sweep_step.sv
// One channel's sweep update: prescaler advance, period/amp next value, clamp and disable.
// Latency: combinational.
// Backpressure: none; caller decides whether the computed step is committed.
module pwl_sweep_step
    import pwl_sweep_pkg::*;
#(
    parameter int PERIOD_BITS = 13,
    parameter int AMP_BITS    = 6
) (
    input  logic [PERIOD_BITS-1:0] period,
    input  logic [AMP_BITS-1:0]    amp,
    input  sweep_t                 sweep0,
    input  sweep_t                 sweep1,
    input  presc_t                 cnt0,
    input  presc_t                 cnt1,
    output logic [PERIOD_BITS-1:0] period_nxt,
    output logic                   period_step,
    output logic                   period_sat,
    output presc_t                 cnt0_nxt,
    output logic [AMP_BITS-1:0]    amp_nxt,
    output logic                   amp_step,
    output logic                   amp_sat,
    output presc_t                 cnt1_nxt
);
    localparam logic [PERIOD_BITS:0] P_MAX = {1'b0, {PERIOD_BITS{1'b1}}};
    localparam logic [AMP_BITS:0]    A_MAX = {1'b0, {AMP_BITS{1'b1}}};

    logic [PERIOD_BITS-1:0] delta_raw;
    logic [PERIOD_BITS-1:0] delta;
    logic [PERIOD_BITS:0]   p_up;
    logic [AMP_BITS:0]      a_up;
    logic                   p_clamp;
    logic                   a_clamp;
    logic                   unused_bits;

    // Amp sweep has no shift; bits 13:12 are storage only
    assign unused_bits = ^{sweep0[13:12], sweep1[13:8]};

    // Prescalers: a step fires when the counter has reached the rate
    always_comb begin
        period_step = sweep0[SW_EN] && (cnt0 == sweep0[SW_RATE +: SW_RATE_BITS]);
        amp_step    = sweep1[SW_EN] && (cnt1 == sweep1[SW_RATE +: SW_RATE_BITS]);
        cnt0_nxt    = cnt0;
        cnt1_nxt    = cnt1;
        if (sweep0[SW_EN]) cnt0_nxt = period_step ? '0 : cnt0 + presc_t'(1);
        if (sweep1[SW_EN]) cnt1_nxt = amp_step    ? '0 : cnt1 + presc_t'(1);
    end

    // Exponential period step with clamp to [1, max]; one extra bit catches overflow
    always_comb begin
        delta_raw  = period >> sweep0[SW_SHIFT +: SW_SHIFT_BITS];
        delta      = (delta_raw == '0) ? PERIOD_BITS'(1) : delta_raw;
        p_up       = {1'b0, period} + {1'b0, delta};
        p_clamp    = 1'b0;
        period_nxt = period;
        if (sweep0[SW_DIR]) begin
            if (p_up > P_MAX) begin
                period_nxt = P_MAX[PERIOD_BITS-1:0];
                p_clamp    = 1'b1;
            end else begin
                period_nxt = p_up[PERIOD_BITS-1:0];
            end
        end else begin
            if (delta >= period) begin
                period_nxt = PERIOD_BITS'(1);
                p_clamp    = 1'b1;
            end else begin
                period_nxt = period - delta;
            end
        end
        period_sat = period_step && p_clamp;
    end

    // Linear amp step; hitting a bound leaves amp unchanged and saturates
    always_comb begin
        a_up    = {1'b0, amp} + {{AMP_BITS{1'b0}}, 1'b1};
        a_clamp = 1'b0;
        amp_nxt = amp;
        if (sweep1[SW_DIR]) begin
            if (a_up > A_MAX) a_clamp = 1'b1;
            else              amp_nxt = a_up[AMP_BITS-1:0];
        end else begin
            if (amp == '0) a_clamp = 1'b1;
            else           amp_nxt = amp - AMP_BITS'(1);
        end
        amp_sat = amp_step && a_clamp;
    end
endmodule

// File: rtl/pwl_sweep_engine.sv
// Per-channel period/amp registers with time-multiplexed exponential/linear sweeps on each tick.
// Latency: tick at T -> busy T+1..T+NUM_CH, channel k committed at end of T+1+k; writes visible next cycle.
// Backpressure: none; a tick during a pass is dropped and flagged in sticky overrun.
module pwl_sweep_engine
    import pwl_sweep_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PERIOD_BITS = 13,
    parameter int AMP_BITS    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    pwl_sweep_if.slave bus
);
    localparam int CH_BITS = $clog2(NUM_CH);

    logic [PERIOD_BITS-1:0] period_q [NUM_CH];
    logic [AMP_BITS-1:0]    amp_q    [NUM_CH];
    sweep_t                 sw0_q    [NUM_CH];
    sweep_t                 sw1_q    [NUM_CH];
    presc_t                 cnt0_q   [NUM_CH];
    presc_t                 cnt1_q   [NUM_CH];
    logic [2*NUM_CH-1:0]    sat_q;
    logic                   overrun_q;
    state_t                 state_q;
    state_t                 state_d;
    logic [CH_BITS-1:0]     ch_q;
    logic                   run;
    logic                   last_ch;

    logic [CH_BITS-1:0]     wr_ch;
    logic [1:0]             wr_fld;
    logic                   coll_p;
    logic                   coll_a;

    logic [PERIOD_BITS-1:0] period_nxt;
    logic [AMP_BITS-1:0]    amp_nxt;
    logic                   period_step;
    logic                   period_sat;
    logic                   amp_step;
    logic                   amp_sat;
    presc_t                 cnt0_nxt;
    presc_t                 cnt1_nxt;

    assign wr_ch   = bus.wr_addr[CH_BITS+1:2];
    assign wr_fld  = bus.wr_addr[1:0];
    assign last_ch = (ch_q == CH_BITS'(NUM_CH - 1));

    // A same-cycle write to a field (or its sweep register) of the channel in its slot discards that sweep step
    assign coll_p = bus.wr_en && (wr_ch == ch_q) && (wr_fld == FIELD_PERIOD || wr_fld == FIELD_SWEEP0);
    assign coll_a = bus.wr_en && (wr_ch == ch_q) && (wr_fld == FIELD_AMP    || wr_fld == FIELD_SWEEP1);

    pwl_sweep_step #(
        .PERIOD_BITS (PERIOD_BITS),
        .AMP_BITS    (AMP_BITS)
    ) u_step (
        .period      (period_q[ch_q]),
        .amp         (amp_q[ch_q]),
        .sweep0      (sw0_q[ch_q]),
        .sweep1      (sw1_q[ch_q]),
        .cnt0        (cnt0_q[ch_q]),
        .cnt1        (cnt1_q[ch_q]),
        .period_nxt  (period_nxt),
        .period_step (period_step),
        .period_sat  (period_sat),
        .cnt0_nxt    (cnt0_nxt),
        .amp_nxt     (amp_nxt),
        .amp_step    (amp_step),
        .amp_sat     (amp_sat),
        .cnt1_nxt    (cnt1_nxt)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: one pass over all channels per accepted tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.tick) state_d = ST_RUN;
            ST_RUN:  if (last_ch)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        run = (state_q == ST_RUN);
    end

    assign bus.busy = run;

    // Channel slot pointer, advanced once per RUN cycle and parked at 0 when idle
    always_ff @(posedge clk) begin
        if (!rst_n)   ch_q <= '0;
        else if (run) ch_q <= ch_q + CH_BITS'(1);
        else          ch_q <= '0;
    end

    // Sticky overrun: set by any tick during a pass, set beats clear
    always_ff @(posedge clk) begin
        if (!rst_n)                 overrun_q <= 1'b0;
        else if (run && bus.tick)   overrun_q <= 1'b1;
        else if (bus.clr_overrun)   overrun_q <= 1'b0;
    end

    // Channel storage: sweep commit for the slot channel, then register writes override
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                period_q[k] <= '0;
                amp_q[k]    <= '0;
                sw0_q[k]    <= '0;
                sw1_q[k]    <= '0;
                cnt0_q[k]   <= '0;
                cnt1_q[k]   <= '0;
            end
            sat_q <= '0;
        end else begin
            if (run) begin
                cnt0_q[ch_q] <= cnt0_nxt;
                cnt1_q[ch_q] <= cnt1_nxt;
                if (period_step && !coll_p) begin
                    period_q[ch_q] <= period_nxt;
                    if (period_sat) begin
                        sw0_q[ch_q][SW_EN]    <= 1'b0;
                        sat_q[{ch_q, 1'b0}]   <= 1'b1;
                    end
                end
                if (amp_step && !coll_a) begin
                    amp_q[ch_q] <= amp_nxt;
                    if (amp_sat) begin
                        sw1_q[ch_q][SW_EN]    <= 1'b0;
                        sat_q[{ch_q, 1'b1}]   <= 1'b1;
                    end
                end
            end
            if (bus.wr_en) begin
                case (wr_fld)
                    FIELD_PERIOD: period_q[wr_ch] <= bus.wr_data[PERIOD_BITS-1:0];
                    FIELD_AMP:    amp_q[wr_ch]    <= bus.wr_data[AMP_BITS-1:0];
                    FIELD_SWEEP0: begin
                        sw0_q[wr_ch]           <= bus.wr_data;
                        cnt0_q[wr_ch]          <= '0;
                        sat_q[{wr_ch, 1'b0}]   <= 1'b0;
                    end
                    default: begin
                        sw1_q[wr_ch]           <= bus.wr_data;
                        cnt1_q[wr_ch]          <= '0;
                        sat_q[{wr_ch, 1'b1}]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Flat output buses straight from the channel registers
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign bus.periods[g*PERIOD_BITS +: PERIOD_BITS] = period_q[g];
        assign bus.amps[g*AMP_BITS +: AMP_BITS]          = amp_q[g];
    end

    assign bus.sat     = sat_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_pwl_sweep_engine.sv
// Directed and randomized checks of the sweep engine against an arithmetic reference model.
// Latency: model advances one step per clock edge and is compared 1 time unit later.
// Backpressure: n/a.
module tb_pwl_sweep_engine;
    localparam int NUM_CH  = 4;
    localparam int PB      = 13;
    localparam int AB      = 6;
    localparam int CH_BITS = $clog2(NUM_CH);
    localparam int PMAX    = (1 << PB) - 1;
    localparam int AMAX    = (1 << AB) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwl_sweep_if #(.NUM_CH(NUM_CH), .PERIOD_BITS(PB), .AMP_BITS(AB)) bus ();

    pwl_sweep_engine #(.NUM_CH(NUM_CH), .PERIOD_BITS(PB), .AMP_BITS(AB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int          m_per [NUM_CH];
    int          m_amp [NUM_CH];
    int unsigned m_sw0 [NUM_CH];
    int unsigned m_sw1 [NUM_CH];
    int          m_c0  [NUM_CH];
    int          m_c1  [NUM_CH];
    bit [2*NUM_CH-1:0] m_sat;
    bit          m_ovr;
    int          m_pass = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_period(int k);
        int p, d, r;
        p = m_per[k];
        d = p >> ((m_sw0[k] >> 8) & 15);
        if (d == 0) d = 1;
        r = ((m_sw0[k] >> 14) & 1) ? p + d : p - d;
        if (r > PMAX) begin
            r = PMAX; m_sw0[k] &= ~(32'd1 << 15); m_sat[2*k] = 1'b1;
        end else if (r < 1) begin
            r = 1;    m_sw0[k] &= ~(32'd1 << 15); m_sat[2*k] = 1'b1;
        end
        m_per[k] = r;
    endfunction

    function automatic void model_amp(int k);
        int r;
        r = ((m_sw1[k] >> 14) & 1) ? m_amp[k] + 1 : m_amp[k] - 1;
        if (r > AMAX || r < 0) begin
            m_sw1[k] &= ~(32'd1 << 15); m_sat[2*k+1] = 1'b1;
        end else begin
            m_amp[k] = r;
        end
    endfunction

    // One clock edge of the reference behaviour, using the inputs held across that edge
    task automatic model_step();
        int wch, wfld;
        bit ovr_set;
        wch = int'(bus.wr_addr) >> 2;
        wfld = int'(bus.wr_addr) & 3;
        ovr_set = 1'b0;
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_per[k] = 0; m_amp[k] = 0; m_sw0[k] = 0; m_sw1[k] = 0; m_c0[k] = 0; m_c1[k] = 0;
            end
            m_sat = '0; m_ovr = 1'b0; m_pass = -1;
            return;
        end
        if (m_pass >= 0) begin
            int k;
            bit wp, wa;
            k = m_pass;
            wp = bus.wr_en && wch == k && (wfld == 0 || wfld == 2);
            wa = bus.wr_en && wch == k && (wfld == 1 || wfld == 3);
            if ((m_sw0[k] >> 15) & 1) begin
                if (m_c0[k] == int'(m_sw0[k] & 255)) begin
                    m_c0[k] = 0;
                    if (!wp) model_period(k);
                end else m_c0[k] = (m_c0[k] + 1) & 255;
            end
            if ((m_sw1[k] >> 15) & 1) begin
                if (m_c1[k] == int'(m_sw1[k] & 255)) begin
                    m_c1[k] = 0;
                    if (!wa) model_amp(k);
                end else m_c1[k] = (m_c1[k] + 1) & 255;
            end
            if (bus.tick) ovr_set = 1'b1;
            m_pass = (k == NUM_CH - 1) ? -1 : k + 1;
        end else if (bus.tick) begin
            m_pass = 0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (bus.clr_overrun) m_ovr = 1'b0;
        if (bus.wr_en) begin
            case (wfld)
                0: m_per[wch] = int'(bus.wr_data) & PMAX;
                1: m_amp[wch] = int'(bus.wr_data) & AMAX;
                2: begin m_sw0[wch] = bus.wr_data; m_c0[wch] = 0; m_sat[2*wch] = 1'b0; end
                default: begin m_sw1[wch] = bus.wr_data; m_c1[wch] = 0; m_sat[2*wch+1] = 1'b0; end
            endcase
        end
    endtask

    task automatic check_all();
        logic [63:0] ep, ea;
        ep = '0; ea = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ep[k*PB +: PB] = PB'(m_per[k]);
            ea[k*AB +: AB] = AB'(m_amp[k]);
        end
        chk("periods", 64'(bus.periods), ep);
        chk("amps",    64'(bus.amps), ea);
        chk("sat",     64'(bus.sat), 64'(m_sat));
        chk("busy",    64'(bus.busy), 64'(m_pass >= 0));
        chk("overrun", 64'(bus.overrun), 64'(m_ovr));
    endtask

    // Inputs are set by the caller; one edge, model update, check, then strobes drop
    task automatic clk_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        bus.wr_en = 1'b0; bus.tick = 1'b0; bus.clr_overrun = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    task automatic wr(input int ch, input int fld, input logic [15:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = {CH_BITS'(ch), 2'(fld)};
        bus.wr_data = d;
        clk_cycle();
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        clk_cycle();
    endtask

    initial begin
        int nb;
        logic [15:0] d;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.tick = 1'b0; bus.clr_overrun = 1'b0;

        // Reset and idle
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(10);
        chk("rst_periods", 64'(bus.periods), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        // Exponential up sweep on ch0, busy length
        wr(0, 0, 16'd1000);
        wr(0, 2, 16'hC400);
        do_tick();
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy) nb++;
            idle(1);
        end
        chk("busy_len", 64'(nb), 64'(NUM_CH));
        chk("p0_1062", 64'(bus.periods[0 +: PB]), 64'd1062);

        // Down sweep on ch1 clamps to 1
        wr(1, 0, 16'd3);
        wr(1, 2, 16'h8000);
        do_tick();
        idle(6);
        chk("p1_clamp", 64'(bus.periods[PB +: PB]), 64'd1);
        chk("sat2_set", 64'(bus.sat[2]), 64'd1);
        do_tick();
        idle(6);
        chk("p1_hold", 64'(bus.periods[PB +: PB]), 64'd1);
        wr(1, 2, 16'h8000);
        chk("sat2_clr", 64'(bus.sat[2]), 64'd0);

        // Linear amp sweep on ch2 with rate 2
        wr(2, 1, 16'd62);
        wr(2, 3, 16'hC002);
        for (int t = 1; t <= 6; t++) begin
            do_tick();
            idle(5);
            if (t == 3) chk("a2_63", 64'(bus.amps[2*AB +: AB]), 64'd63);
        end
        chk("a2_hold", 64'(bus.amps[2*AB +: AB]), 64'd63);
        chk("sat5_set", 64'(bus.sat[5]), 64'd1);

        // Overrun set, clear, and set-beats-clear
        do_tick();
        idle(1);
        do_tick();
        chk("ovr_set", 64'(bus.overrun), 64'd1);
        idle(6);
        bus.clr_overrun = 1'b1;
        clk_cycle();
        chk("ovr_clr", 64'(bus.overrun), 64'd0);
        do_tick();
        bus.tick = 1'b1; bus.clr_overrun = 1'b1;
        clk_cycle();
        chk("ovr_win", 64'(bus.overrun), 64'd1);
        idle(6);

        // Write collides with ch3 sweep slot
        wr(3, 0, 16'd100);
        wr(3, 2, 16'hC000);
        do_tick();
        idle(3);
        wr(3, 0, 16'd500);
        chk("p3_wr_win", 64'(bus.periods[3*PB +: PB]), 64'd500);
        idle(3);

        // Reset in the middle of a pass
        do_tick();
        idle(1);
        rst_n = 1'b0;
        clk_cycle();
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_per", 64'(bus.periods), 64'd0);
        chk("rst_mid_sat", 64'(bus.sat), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int fld;
                fld = $urandom_range(0, 3);
                if (fld >= 2) begin
                    d = 16'(($urandom_range(0, 3) != 0) << 15);
                    d |= 16'($urandom_range(0, 1) << 14);
                    d |= 16'($urandom_range(0, 3) << 12);
                    d |= 16'($urandom_range(0, 15) << 8);
                    d |= 16'($urandom_range(0, 3));
                end else begin
                    d = 16'($urandom);
                end
                bus.wr_en = 1'b1;
                bus.wr_addr = {CH_BITS'($urandom_range(0, NUM_CH - 1)), 2'(fld)};
                bus.wr_data = d;
            end
            bus.tick = ($urandom_range(0, 5) == 0);
            bus.clr_overrun = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            clk_cycle();
        end
        rst_n = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
